// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-client memory read arbiter: FSM encodings,
// client identifiers and request field widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic CLIENT_I = 1'b0;
  localparam logic CLIENT_D = 1'b1;

  localparam int LEN_W  = 32;
  localparam int SIZE_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the client named by prio.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any    = |valid;
    winner = CLIENT_I;
    case (valid)
      2'b01:   winner = CLIENT_I;
      2'b10:   winner = CLIENT_D;
      2'b11:   winner = prio;
      default: winner = CLIENT_I;
    endcase
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one AXI-style read port between instruction- and data-side refill
// clients; the granted client owns the port until its whole burst returns.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              c_read_request_valid,
  output logic [1:0]              c_read_request_ready,
  input  logic [2*AXI_AWIDTH-1:0] c_read_request_addr,
  input  logic [2*LEN_W-1:0]      c_read_len,
  input  logic [2*SIZE_W-1:0]     c_read_size,
  output logic [AXI_DWIDTH-1:0]   c_read_data,
  output logic [1:0]              c_read_data_valid,
  input  logic [1:0]              c_read_data_ready,
  output logic                    read_request_valid,
  input  logic                    read_request_ready,
  output logic [AXI_AWIDTH-1:0]   read_request_addr,
  output logic [LEN_W-1:0]        read_len,
  output logic [SIZE_W-1:0]       read_size,
  input  logic [AXI_DWIDTH-1:0]   read_data,
  input  logic                    read_data_valid,
  output logic                    read_data_ready
);

  arb_state_t       state;
  logic             grant;
  logic             prio;
  logic             pick_winner;
  logic             pick_any;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             req_fire;
  logic             beat_fire;

  rr_pick2 u_pick (
    .valid  (c_read_request_valid),
    .prio   (prio),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Request/beat handshakes pass straight through to the granted client so
  // the arbiter adds no cycles per beat; only the state itself is registered.
  always_comb begin
    if (grant == CLIENT_D) begin
      read_request_addr = c_read_request_addr[AXI_AWIDTH +: AXI_AWIDTH];
      read_len          = c_read_len[LEN_W +: LEN_W];
      read_size         = c_read_size[SIZE_W +: SIZE_W];
    end else begin
      read_request_addr = c_read_request_addr[0 +: AXI_AWIDTH];
      read_len          = c_read_len[0 +: LEN_W];
      read_size         = c_read_size[0 +: SIZE_W];
    end

    read_request_valid   = (state == REQ);
    c_read_request_ready = 2'b00;
    if (state == REQ) c_read_request_ready[grant] = read_request_ready;

    read_data_ready   = (state == DATA) && c_read_data_ready[grant];
    c_read_data_valid = 2'b00;
    if (state == DATA) c_read_data_valid[grant] = read_data_valid;

    c_read_data = read_data;
  end

  assign req_fire  = read_request_valid && read_request_ready;
  assign beat_fire = read_data_ready && read_data_valid;

  // End of burst is an equality compare, so len_q = all-ones needs no guard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= CLIENT_I;
      prio     <= CLIENT_I;
      beat_cnt <= '0;
      len_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_winner;
            state <= REQ;
          end
        end
        REQ: begin
          if (req_fire) begin
            len_q    <= read_len;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (beat_cnt == len_q) begin
              state <= IDLE;
              prio  <= ~grant;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: clients and memory are modelled by an
// environment loop, a monitor pops expected requests/beats as they fire.
module tb_mem_read_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  c_read_request_valid;
  logic [1:0]  c_read_request_ready;
  logic [63:0] c_read_request_addr;
  logic [63:0] c_read_len;
  logic [5:0]  c_read_size;
  logic [31:0] c_read_data;
  logic [1:0]  c_read_data_valid;
  logic [1:0]  c_read_data_ready;
  logic        read_request_valid;
  logic        read_request_ready;
  logic [31:0] read_request_addr;
  logic [31:0] read_len;
  logic [2:0]  read_size;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        read_data_ready;

  mem_read_arbiter #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .c_read_request_valid (c_read_request_valid),
    .c_read_request_ready (c_read_request_ready),
    .c_read_request_addr  (c_read_request_addr),
    .c_read_len           (c_read_len),
    .c_read_size          (c_read_size),
    .c_read_data          (c_read_data),
    .c_read_data_valid    (c_read_data_valid),
    .c_read_data_ready    (c_read_data_ready),
    .read_request_valid   (read_request_valid),
    .read_request_ready   (read_request_ready),
    .read_request_addr    (read_request_addr),
    .read_len             (read_len),
    .read_size            (read_size),
    .read_data            (read_data),
    .read_data_valid      (read_data_valid),
    .read_data_ready      (read_data_ready)
  );

  typedef struct {
    logic        c;
    logic [31:0] addr;
    logic [31:0] len;
    logic [2:0]  size;
  } req_t;

  typedef struct {
    logic        c;
    logic [31:0] data;
    logic        last;
  } beat_t;

  req_t  exp_req[$];
  beat_t exp_beat[$];
  req_t  cq0[$];
  req_t  cq1[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int beats_seen = 0;
  int last_cyc = 0;
  int last_gap = 0;

  logic        mem_busy;
  logic [31:0] m_addr;
  logic [31:0] m_len;
  logic [31:0] m_beat;
  logic        s_rq_fire;
  logic        s_d_fire;
  logic [1:0]  s_c_fire;
  logic [31:0] s_addr;
  logic [31:0] s_len;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic client_push(input logic c, input logic [31:0] a, input logic [31:0] l,
                             input logic [2:0] s);
    req_t r;
    r.c = c; r.addr = a; r.len = l; r.size = s;
    if (c) cq1.push_back(r);
    else   cq0.push_back(r);
  endtask

  task automatic expect_req(input logic c, input logic [31:0] a, input logic [31:0] l,
                            input logic [2:0] s, input int nb);
    req_t  r;
    beat_t b;
    r.c = c; r.addr = a; r.len = l; r.size = s;
    exp_req.push_back(r);
    for (int i = 0; i < nb; i++) begin
      b.c    = c;
      b.data = a + 32'(i);
      b.last = (32'(i) == l);
      exp_beat.push_back(b);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_req.size() != 0 || exp_beat.size() != 0 || cq0.size() != 0 ||
            cq1.size() != 0 || mem_busy) && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_complete"}, 64'(n < 500), 64'(1));
    @(posedge clk); #2;
  endtask

  task automatic wait_beats(input string name, input int target);
    int n = 0;
    while (beats_seen < target && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_beats_reached"}, 64'(n < 500), 64'(1));
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Environment: client request queues and a memory model returning addr+beat.
  initial begin
    mem_busy = 1'b0;
    m_addr = '0; m_len = '0; m_beat = '0;
    read_request_ready = 1'b0;
    read_data_valid = 1'b0;
    read_data = '0;
    c_read_request_valid = '0;
    c_read_request_addr = '0;
    c_read_len = '0;
    c_read_size = '0;
    forever begin
      @(negedge clk);
      s_rq_fire = read_request_valid && read_request_ready;
      s_d_fire  = read_data_valid && read_data_ready;
      s_c_fire  = c_read_request_valid & c_read_request_ready;
      s_addr    = read_request_addr;
      s_len     = read_len;
      @(posedge clk); #1;
      if (!rst) begin
        mem_busy = 1'b0;
        cq0.delete();
        cq1.delete();
      end else begin
        if (s_rq_fire) begin
          m_addr = s_addr; m_len = s_len; m_beat = '0; mem_busy = 1'b1;
        end else if (s_d_fire) begin
          if (m_beat == m_len) mem_busy = 1'b0;
          else m_beat = m_beat + 32'd1;
        end
        if (s_c_fire[0] && cq0.size() > 0) cq0.delete(0);
        if (s_c_fire[1] && cq1.size() > 0) cq1.delete(0);
      end
      c_read_request_valid[0] = (cq0.size() > 0);
      c_read_request_valid[1] = (cq1.size() > 0);
      if (cq0.size() > 0) begin
        c_read_request_addr[31:0] = cq0[0].addr;
        c_read_len[31:0]          = cq0[0].len;
        c_read_size[2:0]          = cq0[0].size;
      end
      if (cq1.size() > 0) begin
        c_read_request_addr[63:32] = cq1[0].addr;
        c_read_len[63:32]          = cq1[0].len;
        c_read_size[5:3]           = cq1[0].size;
      end
      read_request_ready = !mem_busy;
      read_data_valid    = mem_busy;
      read_data          = m_addr + m_beat;
    end
  end

  // Monitor: pops the scoreboard on every request fire and every beat fire.
  initial forever begin
    req_t  r;
    beat_t b;
    @(negedge clk);
    if (rst) begin
      if (read_request_valid && read_request_ready) begin
        last_gap = cyc - last_cyc;
        if (exp_req.size() == 0) begin
          chk("req_unexpected", 64'(1), 64'(0));
        end else begin
          r = exp_req.pop_front();
          chk("req_grant", 64'(c_read_request_ready), 64'(r.c ? 2'b10 : 2'b01));
          chk("req_addr", 64'(read_request_addr), 64'(r.addr));
          chk("req_len", 64'(read_len), 64'(r.len));
          chk("req_size", 64'(read_size), 64'(r.size));
        end
      end
      if (c_read_data_valid != 2'b00)
        chk("dvalid_onehot", 64'($countones(c_read_data_valid) == 1), 64'(1));
      for (int i = 0; i < 2; i++) begin
        if (c_read_data_valid[i] && c_read_data_ready[i]) begin
          beats_seen++;
          if (exp_beat.size() == 0) begin
            chk("beat_unexpected", 64'(1), 64'(0));
          end else begin
            b = exp_beat.pop_front();
            chk("beat_client", 64'(i), 64'(b.c));
            chk("beat_data", 64'(c_read_data), 64'(b.data));
            if (b.last) last_cyc = cyc;
          end
        end
      end
    end
  end

  a_c0_stable: assert property (@(posedge clk) disable iff (!rst)
    (c_read_request_valid[0] && !c_read_request_ready[0]) |=>
    (c_read_request_valid[0] && $stable(c_read_request_addr[31:0]) &&
     $stable(c_read_len[31:0]) && $stable(c_read_size[2:0])));

  a_c1_stable: assert property (@(posedge clk) disable iff (!rst)
    (c_read_request_valid[1] && !c_read_request_ready[1]) |=>
    (c_read_request_valid[1] && $stable(c_read_request_addr[63:32]) &&
     $stable(c_read_len[63:32]) && $stable(c_read_size[5:3])));

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0;
    c_read_data_ready = 2'b11;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(read_request_valid), 64'(0));
    chk("rst_req_ready", 64'(c_read_request_ready), 64'(0));
    chk("rst_data_valid", 64'(c_read_data_valid), 64'(0));
    chk("rst_data_ready", 64'(read_data_ready), 64'(0));
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    // Single client 0 burst with grant latency check
    client_push(1'b0, 32'h100, 32'd3, 3'd2);
    expect_req(1'b0, 32'h100, 32'd3, 3'd2, 4);
    @(negedge clk);
    @(negedge clk);
    chk("lat_cvalid", 64'(c_read_request_valid[0]), 64'(1));
    chk("lat_no_comb_path", 64'(read_request_valid), 64'(0));
    @(negedge clk);
    chk("lat_req_valid", 64'(read_request_valid), 64'(1));
    @(posedge clk); #2;
    wait_idle("t1");

    // Both valid after reset: client 0 first, client 1 two cycles after last beat
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    client_push(1'b0, 32'h200, 32'd1, 3'd2);
    client_push(1'b1, 32'h300, 32'd2, 3'd3);
    expect_req(1'b0, 32'h200, 32'd1, 3'd2, 2);
    expect_req(1'b1, 32'h300, 32'd2, 3'd3, 3);
    wait_idle("t2");
    chk("b2b_gap", 64'(last_gap), 64'(2));

    // Fairness: client 1 held valid, client 0 re-requests
    client_push(1'b0, 32'h400, 32'd1, 3'd1);
    client_push(1'b0, 32'h420, 32'd0, 3'd1);
    client_push(1'b1, 32'h410, 32'd1, 3'd1);
    client_push(1'b1, 32'h430, 32'd2, 3'd1);
    expect_req(1'b0, 32'h400, 32'd1, 3'd1, 2);
    expect_req(1'b1, 32'h410, 32'd1, 3'd1, 2);
    expect_req(1'b0, 32'h420, 32'd0, 3'd1, 1);
    expect_req(1'b1, 32'h430, 32'd2, 3'd1, 3);
    wait_idle("t3");

    // Client 0 backpressure for 5 cycles mid-burst
    base = beats_seen;
    client_push(1'b0, 32'h500, 32'd5, 3'd2);
    expect_req(1'b0, 32'h500, 32'd5, 3'd2, 6);
    wait_beats("t4", base + 2);
    c_read_data_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rd_ready", 64'(read_data_ready), 64'(0));
      chk("stall_dvalid", 64'(c_read_data_valid), 64'(2'b01));
      @(posedge clk); #2;
    end
    c_read_data_ready = 2'b11;
    wait_idle("t4");

    // len 0 burst: one beat then IDLE
    base = beats_seen;
    client_push(1'b1, 32'h600, 32'd0, 3'd0);
    expect_req(1'b1, 32'h600, 32'd0, 3'd0, 1);
    wait_beats("t5", base + 1);
    @(negedge clk);
    chk("len0_idle_rd_ready", 64'(read_data_ready), 64'(0));
    chk("len0_idle_dvalid", 64'(c_read_data_valid), 64'(0));
    @(posedge clk); #2;
    wait_idle("t5");

    // Reset during beat 2 of a len 7 burst
    base = beats_seen;
    client_push(1'b0, 32'h700, 32'd7, 3'd2);
    expect_req(1'b0, 32'h700, 32'd7, 3'd2, 2);
    wait_beats("t6", base + 2);
    chk("mid_dvalid_before", 64'(c_read_data_valid), 64'(2'b01));
    rst = 1'b0;
    #1;
    chk("mid_rst_req_valid", 64'(read_request_valid), 64'(0));
    chk("mid_rst_req_ready", 64'(c_read_request_ready), 64'(0));
    chk("mid_rst_dvalid", 64'(c_read_data_valid), 64'(0));
    chk("mid_rst_rd_ready", 64'(read_data_ready), 64'(0));
    chk("mid_rst_sb_empty", 64'(exp_beat.size()), 64'(0));
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    client_push(1'b1, 32'h800, 32'd1, 3'd2);
    expect_req(1'b1, 32'h800, 32'd1, 3'd2, 2);
    wait_idle("t6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-client read arbiter placed in front of the simulation memory model's AXI-style read channel. It shares the single read port between client 0 (instruction-side refill) and client 1 (data-side refill). Each request is granted to exactly one client at a time, and that client owns the port until every beat of its burst has been delivered. Round-robin priority prevents either client from starving the other.

## Interface
Parameters:
- AXI_AWIDTH, 32, request address width
- AXI_DWIDTH, 32, data beat width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- c_read_request_valid  in  2  per-client request valid, bit i = client i
- c_read_request_ready  out  2  per-client request accept
- c_read_request_addr  in  2*AXI_AWIDTH  client i address at [i*AW +: AW]
- c_read_len  in  64  client i burst length at [i*32 +: 32]; beats = len+1
- c_read_size  in  6  client i beat size (log2 bytes) at [i*3 +: 3]
- c_read_data  out  AXI_DWIDTH  beat data, broadcast to both clients
- c_read_data_valid  out  2  per-client beat valid; at most one bit set
- c_read_data_ready  in  2  per-client beat accept
- read_request_valid  out  1  to memory
- read_request_ready  in  1  from memory
- read_request_addr  out  AXI_AWIDTH  granted client's address
- read_len  out  32  granted client's len
- read_size  out  3  granted client's size
- read_data  in  AXI_DWIDTH  from memory
- read_data_valid  in  1  from memory
- read_data_ready  out  1  to memory

## Operation
- State machine, 2 bits: IDLE, REQ, DATA.
- IDLE:
  - If any c_read_request_valid bit is set, the picker selects a winner. The grant register (1 bit) is loaded and the state goes to REQ.
  - Picker rule: if only one client is valid, it wins. If both are valid, the client named by the priority pointer `prio` wins.
- REQ:
  - read_request_valid = 1.
  - addr, len and size are muxed from the granted client's inputs.
  - c_read_request_ready[grant] = read_request_ready. The other ready bit is 0.
  - On fire, len is latched into len_q, beat_cnt is cleared, and the state goes to DATA.
- DATA:
  - c_read_data_valid[grant] = read_data_valid.
  - read_data_ready = c_read_data_ready[grant].
  - c_read_data = read_data in all states.
  - Each beat fire increments beat_cnt (32 bits).
  - A fire with beat_cnt == len_q is the last beat. It returns the state to IDLE and sets prio = ~grant.
- Clients must hold valid, addr, len and size stable from valid assertion until the request fires. A violation is a bench assertion failure; RTL behaviour is undefined.
- Beats arriving in IDLE or REQ are not forwarded: read_data_ready = 0 and both c_read_data_valid bits = 0.
- len_q = 0xFFFFFFFF: the counter reaches 0xFFFFFFFF on the final beat with no wrap hazard, because the end test is an equality compare.

## Timing
- Reset values (asynchronous, immediate on rst = 0):
  - state = IDLE, grant = 0, prio = 0, beat_cnt = 0, len_q = 0.
  - All valid/ready outputs = 0.
- Grant latency: client valid seen in IDLE in cycle N → read_request_valid = 1 in cycle N+1. There is no combinational valid→valid path.
- Ready paths: request ready and data valid/ready pass through combinationally while granted, so there are zero added cycles per beat.
- Back-to-back grants: after the last beat fires in cycle M, the state is IDLE in M+1 and the next request is issued in M+2.
- Simultaneous events:
  - A new request that arrives during DATA waits; its ready stays 0.
  - Both clients valid in IDLE: the winner is decided by prio.
- Reset mid-burst: the arbiter returns to IDLE at once. The memory model and clients must be reset in the same window; no partial burst is resumed.

## Structure
- Shared package `mem_arb_pkg`:
  - State encodings IDLE = 0, REQ = 1, DATA = 2.
  - Client ids CLIENT_I = 0, CLIENT_D = 1.
  - Field width constants LEN_W = 32, SIZE_W = 3.
- Sub-module `rr_pick2`: combinational picker. Inputs valid[1:0] and prio; outputs winner and any.
- Top-level content: state, grant and prio registers, beat counter, and muxes.

## Test plan
- Single client 0 request, addr 0x100, len 3, size 2 → one memory request with addr 0x100, len 3. Exactly 4 beats reach client 0; client 1 data valid stays 0.
- Both clients valid in the same cycle after reset → client 0 granted first. Client 1 is granted on the next IDLE and issues its request 2 cycles after client 0's last beat.
- Client 1 holds valid continuously across three bursts while client 0 re-requests each time → grants alternate 0, 1, 0, 1, with no starvation.
- Client 0 drops c_read_data_ready for 5 cycles mid-burst → read_data_ready drops for the same 5 cycles, beat_cnt holds, and no beat is lost or duplicated.
- len 0 burst → exactly one beat delivered, then IDLE in the next cycle.
- rst pulled low during beat 2 of a len 7 burst → all outputs 0 asynchronously. After release, a fresh client 1 request is granted normally.
